// File: rtl/l2_wb_cache.sv
// Direct-mapped write-back/write-allocate L2 cache with 256-bit lines and flop-based tag/data arrays.
// Optional macro L2_PERF_CNT_EN adds hit/miss/writeback counter outputs.
module l2_wb_cache #(
    parameter int S_INDEX  = 4,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic [31:0]  wb_count
`endif
);
    localparam int S_TAG = 32 - S_INDEX - S_OFFSET;
    localparam int SETS  = 2 ** S_INDEX;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [255:0]       wdata_q, wdata_d;
    logic               is_write_q, is_write_d;
    logic               first_q, first_d;
    logic               pmem_read_q, pmem_read_d;
    logic               pmem_write_q, pmem_write_d;
    logic [31:0]        pmem_addr_q, pmem_addr_d;
    logic [255:0]       pmem_wdata_q, pmem_wdata_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]    dirty_q, dirty_d;

    logic [255:0]       data_arr_q [SETS];
    logic [S_TAG-1:0]   tag_arr_q  [SETS];

    logic               data_we;
    logic               tag_we;
    logic [255:0]       data_wval;
    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   req_tag;
    logic               hit;

    assign idx     = addr_q[S_OFFSET +: S_INDEX];
    assign req_tag = addr_q[31 -: S_TAG];
    assign hit     = (state_q == COMPARE) && valid_q[idx] && (tag_arr_q[idx] == req_tag);

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_addr_q;
    assign pmem_wdata   = pmem_wdata_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        is_write_d   = is_write_q;
        first_d      = first_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        data_wval    = wdata_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d     = mem_address;
                    wdata_d    = mem_wdata;
                    is_write_d = mem_write;
                    first_d    = 1'b1;
                    state_d    = COMPARE;
                end
            end
            COMPARE: begin
                first_d = 1'b0;
                if (hit) begin
                    mem_resp  = 1'b1;
                    mem_rdata = data_arr_q[idx];
                    if (is_write_q) begin
                        data_we      = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end
                    state_d = IDLE;
                end else if (dirty_q[idx]) begin
                    pmem_write_d = 1'b1;
                    pmem_addr_d  = {tag_arr_q[idx], idx, {S_OFFSET{1'b0}}};
                    pmem_wdata_d = data_arr_q[idx];
                    state_d      = WRITEBACK;
                end else begin
                    pmem_read_d = 1'b1;
                    pmem_addr_d = {req_tag, idx, {S_OFFSET{1'b0}}};
                    state_d     = FILL;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    pmem_write_d = 1'b0;
                    dirty_d[idx] = 1'b0;
                    pmem_read_d  = 1'b1;
                    pmem_addr_d  = {req_tag, idx, {S_OFFSET{1'b0}}};
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    data_we      = 1'b1;
                    data_wval    = pmem_rdata;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    // Re-enter COMPARE so a write miss merges its data into the fresh line.
                    state_d      = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_write_q   <= 1'b0;
            first_q      <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            is_write_q   <= is_write_d;
            first_q      <= first_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Line contents and tags survive reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (data_we) data_arr_q[idx] <= data_wval;
        if (tag_we)  tag_arr_q[idx]  <= req_tag;
    end

`ifdef L2_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state_q == COMPARE && first_q && hit)  hit_count  <= hit_count + 32'd1;
            if (state_q == COMPARE && first_q && !hit) miss_count <= miss_count + 32'd1;
            if (state_q == WRITEBACK && pmem_resp)     wb_count   <= wb_count + 32'd1;
        end
    end
`endif

    always @(posedge clk) begin
        if (reset_n && state_q == IDLE)
            assert (!(mem_read && mem_write))
            else $warning("l2_wb_cache: read and write both high, servicing as write");
    end

endmodule

// File: tb/tb_l2_wb_cache.sv
// Randomized self-checking bench for l2_wb_cache against an ideal-memory plus cache-state model.
module tb_l2_wb_cache;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_wdata = '0;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
`ifdef L2_PERF_CNT_EN
    logic [31:0]  hit_count, miss_count, wb_count;
`endif

    l2_wb_cache dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef L2_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] def_line(input logic [31:0] a);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = a ^ (i * 32'h1111_1111) ^ 32'hC0DE_0000;
        return r;
    endfunction

    // Backing store seen by the downstream port, and the ideal memory the requester expects.
    logic [255:0] backing [logic [31:0]];
    logic [255:0] shadow  [logic [31:0]];

    function automatic logic [255:0] rd_backing(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : def_line(a);
    endfunction
    function automatic logic [255:0] rd_shadow(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : def_line(a);
    endfunction

    logic [31:0]  wb_addr_q[$];
    logic [255:0] wb_data_q[$];
    logic [31:0]  fill_addr_q[$];
    int           hold_override = -1;

    // Downstream responder: random latency, stability checks while waiting, abort on drop.
    always begin
        bit           op_w;
        bit           alive;
        int           dly;
        logic [31:0]  a;
        logic [255:0] d;
        @(negedge clk);
        if (reset_n && (pmem_read || pmem_write)) begin
            op_w  = pmem_write;
            a     = pmem_address;
            d     = pmem_wdata;
            alive = 1'b1;
            dly   = (hold_override >= 0) ? hold_override : int'($urandom_range(0, 3));
            for (int i = 0; i < dly && alive; i++) begin
                @(negedge clk);
                if (!(op_w ? pmem_write : pmem_read)) alive = 1'b0;
                else begin
                    chk("pmem_addr_stable", {224'd0, pmem_address}, {224'd0, a});
                    if (op_w) chk("pmem_wdata_stable", pmem_wdata, d);
                end
            end
            if (alive) begin
                if (op_w) begin
                    backing[a] = d;
                    wb_addr_q.push_back(a);
                    wb_data_q.push_back(d);
                end else begin
                    pmem_rdata = rd_backing(a);
                    fill_addr_q.push_back(a);
                end
                pmem_resp = 1'b1;
                @(negedge clk);
                pmem_resp = 1'b0;
                chk("pmem_req_drop", {255'd0, (op_w ? pmem_write : pmem_read)}, 256'd0);
            end
        end
    end

    int  viol = 0;
    bit  prev_resp = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (pmem_read && pmem_write) viol++;
            if (mem_resp && prev_resp) viol++;
            if (!mem_resp && mem_rdata != '0) viol++;
            prev_resp = mem_resp;
        end else prev_resp = 1'b0;
    end

    // Cache-state model: which line each index holds and whether it differs from backing.
    bit          mv [16];
    bit          md [16];
    logic [22:0] mt [16];
    int m_hits = 0, m_misses = 0, m_wbs = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin mv[i] = 0; md[i] = 0; end
        m_hits = 0; m_misses = 0; m_wbs = 0;
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] wd);
        int           wn0, fn0, cyc, idx;
        bit           got, hit, exp_wb;
        logic [31:0]  line, victim;
        logic [22:0]  tag;
        logic [255:0] rsamp, exp_rd;
        line   = {addr[31:5], 5'd0};
        idx    = int'(addr[8:5]);
        tag    = addr[31:9];
        hit    = mv[idx] && mt[idx] == tag;
        exp_wb = !hit && md[idx];
        victim = {mt[idx], addr[8:5], 5'd0};
        exp_rd = rd_shadow(line);
        wn0 = wb_addr_q.size();
        fn0 = fill_addr_q.size();
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd;
        cyc = 0; got = 0;
        while (cyc < 300 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_resp) got = 1;
        end
        rsamp = mem_rdata;
        mem_read = 0; mem_write = 0;
        chk("resp_seen", {255'd0, got}, 256'd1);
        if (!wr) chk("rdata", rsamp, exp_rd);
        if (hit) chk("hit_latency", 256'(cyc), 256'd1);
        chk("wb_count_req", 256'(wb_addr_q.size() - wn0), 256'(exp_wb));
        if (exp_wb && wb_addr_q.size() > wn0) begin
            chk("wb_addr", {224'd0, wb_addr_q[wn0]}, {224'd0, victim});
            chk("wb_data", wb_data_q[wn0], rd_shadow(victim));
        end
        chk("fill_count_req", 256'(fill_addr_q.size() - fn0), 256'(!hit));
        if (!hit && fill_addr_q.size() > fn0)
            chk("fill_addr", {224'd0, fill_addr_q[fn0]}, {224'd0, line});
        if (hit) m_hits++; else m_misses++;
        if (exp_wb) m_wbs++;
        mv[idx] = 1; mt[idx] = tag;
        if (!hit) md[idx] = 0;
        if (wr) begin
            shadow[line] = wd;
            md[idx] = 1;
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        int cyc;
        logic [255:0] b_line, c_line, d_line;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_resp", {255'd0, mem_resp}, 256'd0);
        chk("reset_pmem_read", {255'd0, pmem_read}, 256'd0);
        chk("reset_pmem_write", {255'd0, pmem_write}, 256'd0);
        chk("reset_pmem_addr", {224'd0, pmem_address}, 256'd0);
        reset_n = 1'b1;

        // Reset in the middle of a fill.
        hold_override = 1000;
        @(posedge clk); #1;
        mem_read = 1; mem_address = 32'h100;
        cyc = 0;
        while (cyc < 20 && !pmem_read) begin @(posedge clk); #1; cyc++; end
        chk("fill_started", {255'd0, pmem_read}, 256'd1);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pmem_read", {255'd0, pmem_read}, 256'd0);
        chk("async_rst_pmem_addr", {224'd0, pmem_address}, 256'd0);
        mem_read = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold_override = -1;
        model_reset();

        // Cold read, then hit on the same line at a different offset.
        do_req(1, 0, 32'h0000_0100, '0);
        do_req(1, 0, 32'h0000_011F, '0);
        // Write hit, then a conflicting read forcing writeback of the dirty line.
        b_line = rnd_line();
        do_req(0, 1, 32'h0000_0100, b_line);
        do_req(1, 0, 32'h0000_0300, '0);
`ifdef L2_PERF_CNT_EN
        #1;
        chk("hit_count_t3", {224'd0, hit_count}, 256'd2);
        chk("miss_count_t3", {224'd0, miss_count}, 256'd2);
        chk("wb_count_t3", {224'd0, wb_count}, 256'd1);
`endif
        // Write miss to a clean slot, read it back, then evict it.
        c_line = rnd_line();
        do_req(0, 1, 32'h0000_0200, c_line);
        do_req(1, 0, 32'h0000_0200, '0);
        do_req(1, 0, 32'h0000_0000, '0);
        chk("evicted_backing", rd_backing(32'h200), c_line);
        // Simultaneous read+write under a long downstream stall.
        d_line = rnd_line();
        hold_override = 20;
        do_req(1, 1, 32'h0000_0100, d_line);
        hold_override = -1;
        do_req(1, 0, 32'h0000_0100, '0);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            bit w;
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | $urandom_range(0, 31);
            w = $urandom_range(0, 1) == 1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_req(!w, w, a, rnd_line());
        end

`ifdef L2_PERF_CNT_EN
        #1;
        chk("hit_count_end", {224'd0, hit_count}, 256'(m_hits));
        chk("miss_count_end", {224'd0, miss_count}, 256'(m_misses));
        chk("wb_count_end", {224'd0, wb_count}, 256'(m_wbs));
`endif
        chk("protocol_violations", 256'(viol), 256'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
